// File: rtl/alu_mul_seq.sv
// Multi-cycle unsigned shift-and-add multiplier that borrows the shared ALU.
// Result is the low WIDTH bits of op_a*op_b; ALU flags are not used.
module alu_mul_seq #(
    parameter int         WIDTH  = 16,
    parameter logic [2:0] OP_ADD = 3'b000,
    parameter logic [2:0] OP_SRL = 3'b110,
    parameter logic [2:0] OP_SLL = 3'b111
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic [2:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TEST,
        S_ADD,
        S_SHL,
        S_SHR,
        S_DONE
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplr;
    logic [WIDTH-1:0] product_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state: one cycle per state, loop TEST->(ADD)->SHL->SHR until mplr empties
    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: if (start) state_n = S_TEST;
            S_TEST: begin
                if (mplr == '0) begin
                    state_n = S_DONE;
                end else if (mplr[0]) begin
                    state_n = S_ADD;
                end else begin
                    state_n = S_SHL;
                end
            end
            S_ADD:  state_n = S_SHL;
            S_SHL:  state_n = S_SHR;
            S_SHR:  state_n = S_TEST;
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Outputs: status flags and ALU operand steering; ALU idles as 0+0
    always_comb begin
        busy   = (state != S_IDLE);
        done   = (state == S_DONE);
        alu_op = OP_ADD;
        alu_a  = '0;
        alu_b  = '0;
        unique case (state)
            S_ADD: begin
                alu_op = OP_ADD;
                alu_a  = acc;
                alu_b  = mcand;
            end
            S_SHL: begin
                alu_op = OP_SLL;
                alu_a  = mcand;
                alu_b  = ONE;
            end
            S_SHR: begin
                alu_op = OP_SRL;
                alu_a  = mplr;
                alu_b  = ONE;
            end
            default: begin
                alu_op = OP_ADD;
                alu_a  = '0;
                alu_b  = '0;
            end
        endcase
    end

    // Datapath: capture operands on accept, write back ALU result per step
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            mcand     <= '0;
            mplr      <= '0;
            product_q <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        acc   <= '0;
                        mcand <= op_a;
                        mplr  <= op_b;
                    end
                end
                S_ADD:  acc       <= alu_result;
                S_SHL:  mcand     <= alu_result;
                S_SHR:  mplr      <= alu_result;
                S_DONE: product_q <= acc;
                default: ;
            endcase
        end
    end

    // Bypass acc in the done cycle so the result is visible alongside done
    assign product = (state == S_DONE) ? acc : product_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed testbench for alu_mul_seq with a behavioural 16-bit ALU beside it.
// Checks latency, product, ALU op trace, start masking and mid-op reset.
module tb_alu_mul_seq;

    localparam int W = 16;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_SLL = 3'b111;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         busy;
    logic         done;
    logic [W-1:0] product;
    logic [2:0]   alu_op;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [W-1:0] alu_result;

    int errors = 0;
    int checks = 0;

    logic [47:0] trace;
    int          ntr;

    alu_mul_seq #(
        .WIDTH (W),
        .OP_ADD(OP_ADD),
        .OP_SRL(OP_SRL),
        .OP_SLL(OP_SLL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy),
        .done      (done),
        .product   (product),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_result(alu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU
    always_comb begin
        alu_result = '0;
        case (alu_op)
            OP_ADD:  alu_result = alu_a + alu_b;
            OP_SRL:  alu_result = alu_a >> alu_b;
            OP_SLL:  alu_result = alu_a << alu_b;
            default: alu_result = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [47:0] got,
                       input logic [47:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present operands with start, return in cycle 1 of the operation
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // mode 0: quiet; 1: pulse start with junk in cycles 3..12;
    // 2: hold start high with 2*3 from cycle 3 onward
    task automatic wait_done(input int mode, output int cyc);
        cyc   = 1;
        ntr   = 0;
        trace = '0;
        while (!done && cyc < 200) begin
            if (alu_op != OP_ADD || alu_a != '0 || alu_b != '0) begin
                trace = {trace[44:0], alu_op};
                ntr++;
            end
            if (mode == 1) begin
                start = (cyc >= 3 && cyc <= 12);
                op_a  = 16'h0009;
                op_b  = 16'h0009;
            end else if (mode == 2 && cyc >= 3) begin
                start = 1'b1;
                op_a  = 16'h0002;
                op_b  = 16'h0003;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        if (mode == 1) start = 1'b0;
        chk("done_timeout", {47'd0, done}, 48'd1);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_p,
                          input int exp_l);
        int cyc;
        start_op(a, b);
        wait_done(0, cyc);
        chk({tag, "_lat"}, 48'(cyc), 48'(exp_l));
        chk({tag, "_prod"}, 48'(product), 48'(exp_p));
        @(posedge clk);
        #1;
        chk({tag, "_hold"}, {31'd0, busy, done, product}, {32'd0, exp_p});
    endtask

    initial begin
        int cyc;
        int ndone;
        logic [47:0] exp_tr;

        rst   = 1'b1;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {47'd0, busy}, 48'd0);
        chk("rst_done", {47'd0, done}, 48'd0);
        chk("rst_prod", 48'(product), 48'd0);
        chk("rst_alu", {alu_op, alu_a, alu_b}, 48'd0);
        rst = 1'b0;

        // multiplier of zero: straight to DONE, ALU untouched
        start_op(16'hFFFF, 16'h0000);
        wait_done(0, cyc);
        chk("zero_lat", 48'(cyc), 48'd2);
        chk("zero_prod", 48'(product), 48'd0);
        chk("zero_trace_n", 48'(ntr), 48'd0);
        @(posedge clk);
        #1;

        // 3*5 with ALU trace
        start_op(16'h0003, 16'h0005);
        wait_done(0, cyc);
        chk("m35_lat", 48'(cyc), 48'd13);
        chk("m35_prod", 48'(product), 48'h000F);
        chk("m35_trace_n", 48'(ntr), 48'd8);
        exp_tr = {24'd0, OP_ADD, OP_SLL, OP_SRL, OP_SLL,
                  OP_SRL, OP_ADD, OP_SLL, OP_SRL};
        chk("m35_trace", trace, exp_tr);
        @(posedge clk);
        #1;
        chk("m35_hold", {31'd0, busy, done, product}, 48'h000F);

        run_op("m1234", 16'h1234, 16'h0010, 16'h2340, 18);
        run_op("wrap", 16'h8000, 16'h0002, 16'h0000, 9);
        run_op("maxb", 16'h0001, 16'hFFFF, 16'hFFFF, 66);
        run_op("ffff", 16'hFFFF, 16'hFFFF, 16'h0001, 66);

        // start pulses while busy are ignored
        start_op(16'h0003, 16'h0005);
        wait_done(1, cyc);
        chk("ign_lat", 48'(cyc), 48'd13);
        chk("ign_prod", 48'(product), 48'h000F);
        @(posedge clk);
        #1;
        chk("ign_idle", {47'd0, busy}, 48'd0);

        // start held high: next op accepted from IDLE right after DONE
        start_op(16'h0003, 16'h0005);
        wait_done(2, cyc);
        chk("hold_lat", 48'(cyc), 48'd13);
        chk("hold_prod", 48'(product), 48'h000F);
        @(posedge clk);
        #1;
        chk("hold_c14_busy", {47'd0, busy}, 48'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("hold_c15_busy", {47'd0, busy}, 48'd1);
        wait_done(0, cyc);
        chk("hold2_lat", 48'(cyc), 48'd10);
        chk("hold2_prod", 48'(product), 48'h0006);
        @(posedge clk);
        #1;

        // reset in cycle 6 of 3*5 aborts and clears product
        start_op(16'h0003, 16'h0005);
        for (int c = 1; c < 6; c++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", {47'd0, busy}, 48'd0);
        chk("abort_prod", 48'(product), 48'd0);
        chk("abort_done", {47'd0, done}, 48'd0);
        rst   = 1'b0;
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (done || busy) ndone++;
        end
        chk("abort_quiet", 48'(ndone), 48'd0);

        run_op("m77", 16'h0007, 16'h0007, 16'h0031, 14);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
